serial_sub: RTL and testbench

Bit-serial, parametrised-width subtractor. Computes `diff = a - b - bin` one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow. It is the sequential, N-bit successor to the combinational one-bit full subtractor in the comb library. It trades latency for area in datapaths where the subtract rate is low.

---
 rtl/serial_sub.sv | 129 ++++++++++++
 tb/tb_serial_sub.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_sub.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b - bin, one bit per clock, LSB first.
// A single full-subtractor cell with a registered borrow; results update only on completion.
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic [1:0]       dbg_state
);

    // Handshake: start is accepted on any rising edge where the block is not in RUN
    // (IDLE or the one-cycle DONE); done is a single-cycle valid strobe for diff/bout/ovf.
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;

    logic             bit_d;
    logic             borrow_nxt;
    logic [WIDTH-1:0] work_shift;
    logic             load;

    always_comb begin
        state_d    = state_q;
        sa_d       = sa_q;
        sb_d       = sb_q;
        work_d     = work_q;
        diff_d     = diff_q;
        cnt_d      = cnt_q;
        br_d       = br_q;
        bout_d     = bout_q;
        ovf_d      = ovf_q;
        bit_d      = sa_q[0] ^ sb_q[0] ^ br_q;
        borrow_nxt = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
        work_shift = {bit_d, work_q[WIDTH-1:1]};
        load       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    load    = 1'b1;
                end
            end
            RUN: begin
                sa_d   = sa_q >> 1;
                sb_d   = sb_q >> 1;
                work_d = work_shift;
                br_d   = borrow_nxt;
                cnt_d  = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    // On the last bit sa_q[0]/sb_q[0] are the original operand MSBs.
                    state_d = DONE;
                    diff_d  = work_shift;
                    bout_d  = borrow_nxt;
                    ovf_d   = (sa_q[0] != sb_q[0]) && (bit_d != sa_q[0]);
                end
            end
            DONE: begin
                if (start) begin
                    state_d = RUN;
                    load    = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            sa_d  = a;
            sb_d  = b;
            br_d  = bin;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            work_q  <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            work_q  <= work_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_sub.sv
// Bench for serial_sub: an 8-bit and a 3-bit instance, driven by tasks and checked
// by a done-triggered monitor against an arithmetic reference model.
module tb_serial_sub;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start8, start3;
    logic [7:0] a8, b8;
    logic       bin8;
    logic [2:0] a3, b3;
    logic       bin3;

    logic       busy8, done8, bout8, ovf8;
    logic [7:0] diff8;
    logic [1:0] dbg8;
    logic       busy3, done3, bout3, ovf3;
    logic [2:0] diff3;
    logic [1:0] dbg3;

    serial_sub #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .ovf(ovf8),
        .dbg_state(dbg8)
    );

    serial_sub #(.WIDTH(3)) u3 (
        .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3), .bin(bin3),
        .busy(busy3), .done(done3), .diff(diff3), .bout(bout3), .ovf(ovf3),
        .dbg_state(dbg3)
    );

    logic [9:0] exp_q8[$];
    logic [9:0] exp_q3[$];
    logic [9:0] last8;
    logic [9:0] mon_act8, mon_exp8, mon_act3, mon_exp3;
    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc++;

    // Reference: plain integer subtraction, packed as {ovf, bout, diff}.
    function automatic logic [9:0] ref_model(int w, int a, int b, int bn);
        int r, d, am, bm, dm;
        logic [7:0] dd;
        logic bo, ov;
        r  = a - b - bn;
        d  = r & ((1 << w) - 1);
        bo = (r < 0);
        am = (a >> (w - 1)) & 1;
        bm = (b >> (w - 1)) & 1;
        dm = (d >> (w - 1)) & 1;
        ov = (am != bm) && (dm != am);
        dd = d[7:0];
        return {ov, bo, dd};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (done8) begin
            mon_act8 = {ovf8, bout8, diff8};
            if (exp_q8.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL done8_unexpected: got result 0x%0h, expected no done", mon_act8);
            end else begin
                mon_exp8 = exp_q8.pop_front();
                check("result8", 32'(mon_act8), 32'(mon_exp8));
                last8 = mon_exp8;
            end
        end
        if (done3) begin
            mon_act3 = {ovf3, bout3, 5'b0, diff3};
            if (exp_q3.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL done3_unexpected: got result 0x%0h, expected no done", mon_act3);
            end else begin
                mon_exp3 = exp_q3.pop_front();
                check("result3", 32'(mon_act3), 32'(mon_exp3));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_op(bit w3, logic [7:0] a, logic [7:0] b, logic bn, bit expect_it);
        if (w3) begin
            a3 = a[2:0]; b3 = b[2:0]; bin3 = bn; start3 = 1'b1;
            if (expect_it) exp_q3.push_back(ref_model(3, int'(a[2:0]), int'(b[2:0]), int'(bn)));
        end else begin
            a8 = a; b8 = b; bin8 = bn; start8 = 1'b1;
            if (expect_it) exp_q8.push_back(ref_model(8, int'(a), int'(b), int'(bn)));
        end
        tick();
        start3 = 1'b0;
        start8 = 1'b0;
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        a3 = 3'($urandom);
        b3 = 3'($urandom);
        if (w3) check("busy3_after_start", 32'(busy3), 32'd1);
        else    check("busy8_after_start", 32'(busy8), 32'd1);
    endtask

    task automatic wait_done(bit w3, int n0);
        int n;
        n = n0;
        while (!(w3 ? done3 : done8) && n < 40) begin
            tick();
            n++;
        end
        if (w3) check("latency3", 32'(n), 32'd3);
        else    check("latency8", 32'(n), 32'd8);
    endtask

    task automatic run_op(bit w3, logic [7:0] a, logic [7:0] b, logic bn);
        begin_op(w3, a, b, bn, 1'b1);
        wait_done(w3, 0);
    endtask

    initial begin
        int t0;
        rst = 1'b1; start8 = 1'b1; start3 = 1'b1;
        a8 = 8'hA5; b8 = 8'h11; bin8 = 1'b1;
        a3 = 3'd5;  b3 = 3'd1;  bin3 = 1'b1;
        last8 = '0;
        repeat (2) tick();
        rst = 1'b0; start8 = 1'b0; start3 = 1'b0;
        check("reset_busy8", 32'(busy8), 32'd0);
        check("reset_done8", 32'(done8), 32'd0);
        check("reset_diff8", 32'(diff8), 32'd0);
        check("reset_bout8", 32'(bout8), 32'd0);
        check("reset_ovf8",  32'(ovf8),  32'd0);
        check("reset_busy3", 32'(busy3), 32'd0);
        check("reset_diff3", 32'(diff3), 32'd0);
        tick();
        check("idle_busy8", 32'(busy8), 32'd0);

        // Directed cases, some back-to-back, some with idle gaps.
        run_op(1'b0, 8'h5A, 8'h3C, 1'b0);
        run_op(1'b0, 8'h00, 8'h01, 1'b0);
        repeat (2) tick();
        run_op(1'b0, 8'h80, 8'h01, 1'b0);
        run_op(1'b0, 8'h00, 8'h00, 1'b1);
        repeat (3) tick();

        // start during RUN must be ignored, and diff must hold the previous result.
        begin_op(1'b0, 8'h5A, 8'h3C, 1'b0, 1'b1);
        repeat (3) tick();
        check("hold8_during_run", 32'(diff8), 32'(last8[7:0]));
        a8 = 8'hFF; b8 = 8'h0F; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        wait_done(1'b0, 4);

        // start in the DONE cycle: next done exactly WIDTH+1 cycles later.
        t0 = cyc;
        begin_op(1'b0, 8'hFF, 8'h0F, 1'b0, 1'b1);
        wait_done(1'b0, 0);
        check("b2b_spacing8", 32'(cyc - t0), 32'd9);
        repeat (2) tick();

        // Reset after bit 3 aborts with no done.
        begin_op(1'b0, 8'h10, 8'h01, 1'b0, 1'b0);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        last8 = '0;
        check("abort_busy8", 32'(busy8), 32'd0);
        check("abort_done8", 32'(done8), 32'd0);
        check("abort_diff8", 32'(diff8), 32'd0);
        check("abort_bout8", 32'(bout8), 32'd0);
        repeat (12) tick();
        check("abort_still_idle8", 32'(busy8), 32'd0);
        run_op(1'b0, 8'h10, 8'h01, 1'b0);

        // Randomised 8-bit operations with random gaps.
        for (int i = 0; i < 40; i++) begin
            run_op(1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 3)) tick();
        end

        // Exhaustive 3-bit sweep, issued back-to-back.
        for (int x = 0; x < 8; x++)
            for (int y = 0; y < 8; y++)
                for (int z = 0; z < 2; z++)
                    run_op(1'b1, 8'(x), 8'(y), 1'(z));

        repeat (3) tick();
        check("drain8", 32'(exp_q8.size()), 32'd0);
        check("drain3", 32'(exp_q3.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
